// File: rtl/sp_pkg.sv
// Shared types and size helpers for the frame sequencer and its watchdog.
package sp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic int n_in(int r_i, int c_i);
    return r_i * c_i;
  endfunction

  function automatic int n_out(int r_i, int c_i, int r_k, int c_k);
    return (r_i - r_k + 1) * (c_i - c_k + 1);
  endfunction

  // Width for a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/watchdog_counter.sv
// Idle-cycle counter: expires after LIMIT consecutive un-held, enabled cycles.
module watchdog_counter
  import sp_pkg::*;
#(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic hold,
  input  logic enable,
  output logic expire
);

  localparam int W = cnt_w(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) cnt_d = '0;
    else if (!hold)       cnt_d = cnt_q + 1'b1;
  end

  // Expiry is suppressed by clear so a same-cycle handshake always wins.
  assign expire = enable && !clear && !hold && (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axis_frame_sequencer.sv
// Admits one image into the filter engine, then forwards its filtered output to TX;
// a stalled host gets its frame zero-padded and the result discarded.
module axis_frame_sequencer
  import sp_pkg::*;
#(
  parameter int R_I            = 7,
  parameter int C_I            = 7,
  parameter int W_I            = 8,
  parameter int R_K            = 3,
  parameter int C_K            = 3,
  parameter int TIMEOUT_CLOCKS = 1000000
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [W_I-1:0] s_rx_data,
  input  logic           s_rx_valid,
  output logic           s_rx_ready,
  output logic [W_I-1:0] m_eng_data,
  output logic           m_eng_valid,
  input  logic           m_eng_ready,
  output logic           m_eng_last,
  input  logic [W_I-1:0] s_eng_data,
  input  logic           s_eng_valid,
  output logic           s_eng_ready,
  input  logic           s_eng_last,
  output logic [W_I-1:0] m_tx_data,
  output logic           m_tx_valid,
  input  logic           m_tx_ready,
  output logic           busy,
  output logic           frame_done,
  output logic           err_timeout,
  output logic           err_len,
  output logic [15:0]    frame_count
);

  localparam int N_IN  = n_in(R_I, C_I);
  localparam int N_OUT = n_out(R_I, C_I, R_K, C_K);
  localparam int IW    = cnt_w(N_IN);
  localparam int OW    = cnt_w(N_OUT);

  state_e        state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          discard_q, discard_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          frame_done_q, frame_done_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_len_q, err_len_d;

  logic in_hs, eng_hs, in_last, out_last, wd_expire;

  assign in_hs    = m_eng_valid && m_eng_ready;
  assign eng_hs   = s_eng_valid && s_eng_ready;
  assign in_last  = (in_cnt_q == IW'(N_IN - 1));
  assign out_last = (out_cnt_q == OW'(N_OUT - 1));

  // Engine backpressure with data pending is not a host stall, hence hold on s_rx_valid.
  watchdog_counter #(.LIMIT(TIMEOUT_CLOCKS)) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (in_hs || (state_q != ST_LOAD)),
    .hold   (s_rx_valid),
    .enable (state_q == ST_LOAD),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_hs) state_d = in_last ? ST_DRAIN : ST_LOAD;
      ST_LOAD: begin
        if (in_hs && in_last)    state_d = ST_DRAIN;
        else if (!in_hs && wd_expire) state_d = ST_PAD;
      end
      ST_PAD:   if (in_hs && in_last)   state_d = ST_DRAIN;
      ST_DRAIN: if (eng_hs && out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // All handshake outputs are forced low during reset so neither stream sees a stray beat.
  always_comb begin
    s_rx_ready  = 1'b0;
    m_eng_data  = '0;
    m_eng_valid = 1'b0;
    m_eng_last  = 1'b0;
    s_eng_ready = 1'b0;
    m_tx_data   = s_eng_data;
    m_tx_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        m_eng_data  = s_rx_data;
        m_eng_valid = s_rx_valid;
        s_rx_ready  = m_eng_ready;
        m_eng_last  = in_last;
      end
      ST_PAD: begin
        m_eng_valid = 1'b1;
        m_eng_last  = in_last;
      end
      ST_DRAIN: begin
        m_tx_valid  = !discard_q && s_eng_valid;
        s_eng_ready = discard_q || m_tx_ready;
      end
      default: ;
    endcase
    if (!rstn) begin
      s_rx_ready  = 1'b0;
      m_eng_valid = 1'b0;
      s_eng_ready = 1'b0;
      m_tx_valid  = 1'b0;
    end
  end

  always_comb begin
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    discard_d     = discard_q;
    if (in_hs)  in_cnt_d  = in_last  ? '0 : in_cnt_q + 1'b1;
    if (eng_hs) out_cnt_d = out_last ? '0 : out_cnt_q + 1'b1;
    if (state_q == ST_PAD && in_hs && in_last)          discard_d = 1'b1;
    else if (state_q == ST_DRAIN && state_d == ST_IDLE) discard_d = 1'b0;
    frame_done_d  = (state_q == ST_DRAIN) && eng_hs && out_last && !discard_q;
    frame_count_d = frame_count_q + 16'(frame_done_d);
    err_timeout_d = (state_q == ST_LOAD) && (state_d == ST_PAD);
    err_len_d     = eng_hs && (s_eng_last != out_last);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      discard_q     <= 1'b0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      discard_q     <= discard_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
      err_len_q     <= err_len_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign err_timeout = err_timeout_q;
  assign err_len     = err_len_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Scoreboard bench: host/engine/TX agents with random pacing, expected beats queued at issue.
module tb_axis_frame_sequencer;

  localparam int R_I = 7, C_I = 7, W_I = 8, R_K = 3, C_K = 3, TO = 100;
  localparam int N_IN = R_I * C_I;
  localparam int OR = R_I - R_K + 1, OC = C_I - C_K + 1;
  localparam int N_OUT = OR * OC;

  typedef struct packed { logic [7:0] d; logic l; } beat_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] s_rx_data = '0;
  logic s_rx_valid = 1'b0, s_rx_ready;
  logic [7:0] m_eng_data;
  logic m_eng_valid, m_eng_ready = 1'b0, m_eng_last;
  logic [7:0] s_eng_data = '0;
  logic s_eng_valid = 1'b0, s_eng_ready, s_eng_last = 1'b0;
  logic [7:0] m_tx_data;
  logic m_tx_valid, m_tx_ready = 1'b0;
  logic busy, frame_done, err_timeout, err_len;
  logic [15:0] frame_count;

  axis_frame_sequencer #(
    .R_I(R_I), .C_I(C_I), .W_I(W_I), .R_K(R_K), .C_K(C_K), .TIMEOUT_CLOCKS(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid), .s_rx_ready(s_rx_ready),
    .m_eng_data(m_eng_data), .m_eng_valid(m_eng_valid), .m_eng_ready(m_eng_ready),
    .m_eng_last(m_eng_last),
    .s_eng_data(s_eng_data), .s_eng_valid(s_eng_valid), .s_eng_ready(s_eng_ready),
    .s_eng_last(s_eng_last),
    .m_tx_data(m_tx_data), .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready),
    .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout), .err_len(err_len),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  beat_t      eng_exp[$];
  logic [7:0] tx_exp[$];
  beat_t      eng_out[$];
  logic [7:0] ebuf[$];
  int total = 0, bad = 0;
  int n_fd = 0, n_to = 0, n_len = 0, outs_seen = 0;
  int exp_fd = 0, exp_fc = 0, exp_to = 0, exp_len = 0;
  bit rdy_all = 1'b0, bp_hold = 1'b0, bad_last = 1'b0, in_flight = 1'b0;
  int gapmax = 3;

  function automatic void chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endfunction

  // Monitor plus engine model: the engine answers each full frame with window-centre pixels.
  always @(negedge clk) begin
    if (!rstn) begin
      eng_exp.delete(); tx_exp.delete(); eng_out.delete(); ebuf.delete();
      in_flight = 1'b0; outs_seen = 0;
    end else begin
      if (in_flight) chk("rx_blocked_in_drain", s_rx_ready, 0);
      if (m_eng_valid && m_eng_ready) begin
        if (eng_exp.size() == 0) chk("eng_unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = eng_exp.pop_front();
          chk("eng_data", m_eng_data, e.d);
          chk("eng_last", m_eng_last, e.l);
        end
        ebuf.push_back(m_eng_data);
        if (ebuf.size() == N_IN) begin
          for (int i = 0; i < N_OUT; i++) begin
            beat_t o;
            o.d = ebuf[(i / OC + 1) * C_I + (i % OC) + 1];
            o.l = (i == (bad_last ? N_OUT - 2 : N_OUT - 1));
            eng_out.push_back(o);
          end
          ebuf.delete();
          in_flight = 1'b1;
          outs_seen = 0;
        end
      end
      if (s_eng_valid && s_eng_ready) begin
        if (eng_out.size() == 0) chk("eng_out_underflow", 1, 0);
        else void'(eng_out.pop_front());
        outs_seen++;
        if (outs_seen == N_OUT) in_flight = 1'b0;
      end
      if (m_tx_valid && m_tx_ready) begin
        if (tx_exp.size() == 0) chk("tx_unexpected_beat", 1, 0);
        else chk("tx_data", m_tx_data, tx_exp.pop_front());
      end
      if (frame_done)  n_fd++;
      if (err_timeout) n_to++;
      if (err_len)     n_len++;
    end
  end

  // Sink/engine pacing; during reset everything is driven high to prove the DUT gates it.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        m_eng_ready = 1'b1; m_tx_ready = 1'b1;
        s_eng_valid = 1'b1; s_eng_data = 8'hFF; s_eng_last = 1'b1;
      end else begin
        m_eng_ready = bp_hold ? 1'b0 : (rdy_all ? 1'b1 : ($urandom_range(3) != 0));
        m_tx_ready  = rdy_all ? 1'b1 : ($urandom_range(3) != 0);
        if (eng_out.size() > 0 && (rdy_all || $urandom_range(3) != 0)) begin
          s_eng_valid = 1'b1; s_eng_data = eng_out[0].d; s_eng_last = eng_out[0].l;
        end else begin
          s_eng_valid = 1'b0; s_eng_data = 8'h00; s_eng_last = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    int cyc = 0;
    s_rx_valid = 1'b1; s_rx_data = b;
    while (!done && cyc < 3000) begin
      @(negedge clk); done = s_rx_ready;
      @(posedge clk); #1; cyc++;
    end
    if (!done) chk("rx_accept_timeout", 0, 1);
    s_rx_valid = 1'b0;
    repeat ($urandom_range(gapmax)) begin @(posedge clk); #1; end
  endtask

  // start >= 0: sequential bytes from start; otherwise random. bp_at stalls the engine 500 cycles.
  task automatic send_frame(input int n, input int start, input int bp_at);
    logic [7:0] pix[N_IN];
    for (int k = 0; k < n; k++) begin
      beat_t e;
      logic [7:0] b;
      b = (start >= 0) ? 8'(start + k) : 8'($urandom);
      pix[k] = b;
      e.d = b; e.l = (k == N_IN - 1);
      eng_exp.push_back(e);
      if (k == N_IN - 1) begin
        for (int r = 1; r <= OR; r++)
          for (int c = 1; c <= OC; c++) tx_exp.push_back(pix[r * C_I + c]);
        exp_fd++; exp_fc++;
      end
      if (k == bp_at) begin
        bp_hold = 1'b1;
        fork begin repeat (500) @(posedge clk); bp_hold = 1'b0; end join_none
      end
      send_byte(b);
    end
  endtask

  task automatic wait_idle(input string nm);
    int cyc = 0;
    while (cyc < 5000 && (eng_exp.size() != 0 || eng_out.size() != 0 ||
           tx_exp.size() != 0 || busy || in_flight)) begin
      @(negedge clk); cyc++;
    end
    chk(nm, int'(cyc < 5000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_count"}, frame_count, exp_fc);
    chk({tag, "_frame_done_pulses"}, n_fd, exp_fd);
    chk({tag, "_timeout_pulses"}, n_to, exp_to);
    chk({tag, "_len_pulses"}, n_len, exp_len);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_rx_ready"}, s_rx_ready, 0);
    chk({tag, "_m_eng_valid"}, m_eng_valid, 0);
    chk({tag, "_m_eng_last"}, m_eng_last, 0);
    chk({tag, "_s_eng_ready"}, s_eng_ready, 0);
    chk({tag, "_m_tx_valid"}, m_tx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pulses"}, {frame_done, err_timeout, err_len}, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    s_rx_valid = 1'b1; s_rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    s_rx_valid = 1'b0;
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;

    // Ramp frame with full-rate readies, then the next frame's first byte offered during DRAIN.
    rdy_all = 1'b1; gapmax = 0;
    send_frame(N_IN, 8'h00, -1);
    send_frame(N_IN, 8'h31, -1);
    wait_idle("idle_after_ramp");
    check_counts("ramp");
    rdy_all = 1'b0; gapmax = 3;

    for (int f = 0; f < 3; f++) send_frame(N_IN, -1, -1);
    wait_idle("idle_after_random");
    check_counts("random");

    // Host stalls after 20 bytes: padding zeros reach the engine, output is dropped.
    send_frame(20, -1, -1);
    for (int k = 20; k < N_IN; k++) begin
      beat_t e;
      e.d = 8'h00; e.l = (k == N_IN - 1);
      eng_exp.push_back(e);
    end
    exp_to++;
    wait_idle("idle_after_timeout");
    check_counts("timeout");

    send_frame(N_IN, -1, 5);
    wait_idle("idle_after_backpressure");
    check_counts("backpressure");

    bad_last = 1'b1;
    send_frame(N_IN, -1, -1);
    exp_len += 2;
    wait_idle("idle_after_badlast");
    bad_last = 1'b0;
    check_counts("badlast");

    // Reset after pixel 30 abandons the frame; a clean frame must then complete.
    send_frame(31, 0, -1);
    rstn = 1'b0; s_rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    s_rx_valid = 1'b0;
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;
    exp_fc = 0;
    send_frame(N_IN, -1, -1);
    wait_idle("idle_after_midreset");
    check_counts("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
